// File: rtl/adv_ddr_rx.sv
// adv_ddr_rx: DDR video receiver. Each pixel arrives as two 12-bit half-words,
// the first on the rising and the second on the falling edge of the pixel
// clock. The pixel clock is treated as data and oversampled on clk (>= 4x).
// A framing FSM tracks DE/vsync to produce pixel coordinates and per-frame
// line-count / geometry status.
//
// Ports:
//   clk, reset           sample clock, synchronous active-high reset
//   i_clk_pixel          pixel clock, sampled as data
//   i_de/i_hsync/i_vsync video controls (active-high)
//   i_data[11:0]         DDR half-pixel word
//   o_valid              one-cycle strobe per reconstructed active pixel
//   o_r/o_g/o_b          reconstructed pixel (held until next o_valid)
//   o_x/o_y              coordinates of the presented pixel
//   o_hsync/o_vsync      syncs captured at the rising pixel-clock edge
//   o_frame_done         one-cycle strobe at frame close
//   o_lines              active-line count of the last closed frame
//   o_frame_ok           last closed frame had exact V_ACT x H_ACT geometry
//   o_locked             set after the first vsync rise
module adv_ddr_rx #(
    parameter int unsigned H_ACT = 1280,
    parameter int unsigned V_ACT = 720
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clk_pixel,
    input  logic        i_de,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [11:0] i_data,
    output logic        o_valid,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_frame_done,
    output logic [11:0] o_lines,
    output logic        o_frame_ok,
    output logic        o_locked
);

    localparam int unsigned CW = 12;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] H_ACT_C = CW'(H_ACT);
    localparam logic [CW-1:0] V_ACT_C = CW'(V_ACT);

    localparam logic [1:0] S_WAIT_VSYNC = 2'd0;
    localparam logic [1:0] S_BLANK      = 2'd1;
    localparam logic [1:0] S_ACTIVE     = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          pclk_q;
    logic [11:0]   lo_half_q, lo_half_d;
    logic          de_q, de_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          lerr_q, lerr_d;

    logic          valid_q, valid_d;
    logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
    logic [CW-1:0] ox_q, ox_d, oy_q, oy_d;
    logic          done_q, done_d;
    logic [CW-1:0] lines_q, lines_d;
    logic          ok_q, ok_d;
    logic          locked_q, locked_d;

    // Edge events on the sampled pixel clock and the captured controls
    logic rise_c, fall_c, de_rise_c, de_fall_c, vs_rise_c;
    logic line_close_c, frame_close_c;
    logic [CW-1:0] y_line_c;
    logic lerr_line_c;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    assign rise_c    = i_clk_pixel & ~pclk_q;
    assign fall_c    = ~i_clk_pixel & pclk_q;
    assign de_rise_c = rise_c & i_de & ~de_q;
    assign de_fall_c = rise_c & ~i_de & de_q;
    assign vs_rise_c = rise_c & i_vsync & ~vs_q;

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        lo_half_d     = lo_half_q;
        de_d          = de_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        pend_d        = pend_q;
        x_d           = x_q;
        y_d           = y_q;
        lerr_d        = lerr_q;
        valid_d       = 1'b0;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        ox_d          = ox_q;
        oy_d          = oy_q;
        done_d        = 1'b0;
        lines_d       = lines_q;
        ok_d          = ok_q;
        locked_d      = locked_q;
        line_close_c  = 1'b0;
        frame_close_c = 1'b0;

        // A rise with a half already pending simply overwrites it
        if (rise_c) begin
            lo_half_d = i_data;
            de_d      = i_de;
            hs_d      = i_hsync;
            vs_d      = i_vsync;
            pend_d    = 1'b1;
        end

        case (state_q)
            S_WAIT_VSYNC: begin
                if (vs_rise_c) begin
                    state_d  = S_BLANK;
                    locked_d = 1'b1;
                end
            end
            S_BLANK: begin
                frame_close_c = vs_rise_c;
                if (de_rise_c) begin
                    state_d = S_ACTIVE;
                    x_d     = '0;
                end
            end
            S_ACTIVE: begin
                // vsync inside a line closes that line before the frame
                frame_close_c = vs_rise_c;
                if (de_fall_c || vs_rise_c) begin
                    line_close_c = 1'b1;
                    state_d      = S_BLANK;
                end
            end
            default: state_d = S_WAIT_VSYNC;
        endcase

        y_line_c    = line_close_c ? sat_inc(y_q) : y_q;
        lerr_line_c = lerr_q | (line_close_c & (x_q != H_ACT_C));

        if (frame_close_c) begin
            done_d  = 1'b1;
            lines_d = y_line_c;
            ok_d    = (y_line_c == V_ACT_C) & ~lerr_line_c;
            y_d     = '0;
            lerr_d  = 1'b0;
        end else begin
            y_d     = y_line_c;
            lerr_d  = lerr_line_c;
        end

        // Second half completes the pixel
        if (fall_c && pend_q) begin
            pend_d = 1'b0;
            if (de_q && (state_q == S_ACTIVE)) begin
                valid_d = 1'b1;
                r_d     = lo_half_q[11:4];
                g_d     = {lo_half_q[3:0], i_data[11:8]};
                b_d     = i_data[7:0];
                ox_d    = x_q;
                oy_d    = y_q;
                x_d     = sat_inc(x_q);
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_WAIT_VSYNC;
            pclk_q    <= 1'b0;
            lo_half_q <= '0;
            de_q      <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            pend_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            lerr_q    <= 1'b0;
            valid_q   <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            done_q    <= 1'b0;
            lines_q   <= '0;
            ok_q      <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pclk_q    <= i_clk_pixel;
            lo_half_q <= lo_half_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            pend_q    <= pend_d;
            x_q       <= x_d;
            y_q       <= y_d;
            lerr_q    <= lerr_d;
            valid_q   <= valid_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            done_q    <= done_d;
            lines_q   <= lines_d;
            ok_q      <= ok_d;
            locked_q  <= locked_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_r          = r_q;
    assign o_g          = g_q;
    assign o_b          = b_q;
    assign o_x          = ox_q;
    assign o_y          = oy_q;
    assign o_hsync      = hs_q;
    assign o_vsync      = vs_q;
    assign o_frame_done = done_q;
    assign o_lines      = lines_q;
    assign o_frame_ok   = ok_q;
    assign o_locked     = locked_q;

endmodule

// File: doc/adv_ddr_rx.md
ADV_DDR_RX -- requirements
Module: adv_ddr_rx

Interface
REQ-001 SHALL have parameter H_ACT, default 1280, active pixels per line.
REQ-002 SHALL have parameter V_ACT, default 720, active lines per frame.
REQ-003 SHALL have port clk  in  1  DDR sample clock, at least 4x pixel clock; sole clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port i_clk_pixel  in  1  pixel clock, sampled as data on clk.
REQ-006 SHALL have ports i_de, i_hsync, i_vsync  in  1 each  data enable, hsync and vsync; all active-high.
REQ-007 SHALL have port i_data  in  12  DDR half-pixel word.
REQ-008 SHALL have port o_valid  out  1  one-cycle strobe for a reconstructed active pixel.
REQ-009 SHALL have ports o_r, o_g, o_b  out  8 each  reconstructed pixel.
REQ-010 SHALL have ports o_x, o_y  out  12 each  coordinates of the pixel presented on o_valid.
REQ-011 SHALL have ports o_hsync, o_vsync  out  1 each  sync signals, registered at the rising pixel-clock edge.
REQ-012 SHALL have port o_frame_done  out  1  one-cycle strobe at frame close.
REQ-013 SHALL have port o_lines  out  12  active-line count of the last closed frame.
REQ-014 SHALL have port o_frame_ok  out  1  last closed frame had exactly V_ACT lines of H_ACT pixels each.
REQ-015 SHALL have port o_locked  out  1  high after the first vsync rising edge.

Function
REQ-016 SHALL register i_clk_pixel in one flop and detect a rise (previous 0, current 1) and a fall (previous 1, current 0).
REQ-017 SHALL on a rise capture i_data into lo_half and capture i_de, i_hsync, i_vsync, and set half_pending.
REQ-018 SHALL on a fall with half_pending set form the pixel as follows and clear half_pending:
  - r = lo_half[11:4]
  - g = {lo_half[3:0], i_data[11:8]}
  - b = i_data[7:0]
REQ-019 SHALL discard the held half when a rise occurs with half_pending already set, with no output.
REQ-020 SHALL ignore a fall without half_pending.
REQ-021 SHALL assert o_valid on the clk cycle after the fall when captured DE=1 and the state is ACTIVE; latency from fall to o_valid is 1 clk.
REQ-022 SHALL hold o_r, o_g, o_b, o_x and o_y stable until the next o_valid.
REQ-023 SHALL implement the FSM below, evaluating all events at rising pixel-clock edges on the captured signals:
  - WAIT_VSYNC: go to BLANK on the first vsync rise; set o_locked.
  - BLANK: go to ACTIVE on a DE rise; clear x.
  - ACTIVE: on a DE fall, record a line error if x != H_ACT, increment y, go to BLANK.
  - In BLANK or ACTIVE, a vsync rise closes the frame.
REQ-024 SHALL increment x (12-bit) per valid pixel and saturate at 4095 without wrap; pixels beyond H_ACT are still output.
REQ-025 SHALL saturate y at 4095.
REQ-026 SHALL on frame close:
  - pulse o_frame_done for 1 clk
  - load o_lines with y
  - load o_frame_ok with (y == V_ACT) and no line error
  - clear y and the line-error flag
REQ-027 SHALL, when a DE fall and a vsync rise occur at the same edge, count the line first and then close the frame with that line included.
REQ-028 SHALL, on a vsync rise during ACTIVE, close the line as if DE fell (line error if x != H_ACT), then close the frame and go to BLANK.
REQ-029 SHALL suppress o_valid while in WAIT_VSYNC.

Reset
REQ-030 SHALL on reset force the following:
  - state WAIT_VSYNC
  - o_valid, o_frame_done, o_frame_ok, o_locked, o_hsync, o_vsync = 0
  - o_r, o_g, o_b = 0
  - o_x, o_y, o_lines = 0
  - half_pending, line error = 0
  - sampled pixel-clock flop = 0
REQ-031 SHALL apply reset mid-frame without emitting a partial o_frame_done, and SHALL require a fresh vsync before any o_valid.

Verification
REQ-032 Pixel clock = clk/4; rise word 12'hAB5, fall word 12'hC3D, DE=1, locked -> o_valid 1 clk after fall with r=8'hAB, g=8'h5C, b=8'h3D.
REQ-033 Full frame of 720 lines x 1280 pixels between vsync rises -> o_frame_done pulse, o_lines=720, o_frame_ok=1, last pixel o_x=1279, o_y=719.
REQ-034 One line of 1279 pixels in an otherwise good frame -> o_lines=720, o_frame_ok=0; next good frame -> o_frame_ok=1.
REQ-035 DE active before any vsync -> no o_valid, o_locked=0; after vsync rise -> o_locked=1 and pixels output.
REQ-036 Two pixel-clock rises with no fall between them -> first half discarded; single correct pixel output after the fall.
REQ-037 Reset asserted at line 300 -> all outputs 0, no o_frame_done; o_valid resumes only after the next vsync rise.
